miinst_queue: RTL and testbench

//   FIFO of decoded micro-instructions (miinst_t) between the x86 instruction decoder/expander
//   and decode_phase. Presents the oldest entry on deq_miinst_head every cycle and pops it when
//   the decode stage advances. Outputs a MIOP_NOP head when empty. Drops all contents on flush.

---
 rtl/miinst_queue_if.sv | 41 ++++
 rtl/miinst_queue.sv | 59 +++++
 tb/tb_miinst_queue.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/miinst_queue_if.sv
// miinst_queue_if: micro-instruction type package and the decoder <-> decode_phase queue interface
package miinst_pkg;
   typedef enum logic [3:0] {
      MIOP_NOP,
      MIOP_ALU,
      MIOP_LOAD,
      MIOP_STORE,
      MIOP_BRANCH,
      MIOP_MOV
   } miop_t;
   typedef struct packed {
      miop_t       opcode;
      logic [31:0] pc;
      logic [3:0]  dst;
      logic [3:0]  src1;
      logic [3:0]  src2;
      logic [31:0] imm;
   } miinst_t;
endpackage

interface miinst_queue_if #(parameter int DEPTH = 16);
   import miinst_pkg::*;
   localparam int AW = $clog2(DEPTH);
   logic          flush;
   logic          enq_valid;
   miinst_t       enq_miinst;
   logic          enq_ready;
   logic          almost_full;
   logic          deq_en;
   miinst_t       deq_miinst_head;
   logic          head_valid;
   logic [AW:0]   count;
   modport master (
      output flush, enq_valid, enq_miinst, deq_en,
      input  enq_ready, almost_full, deq_miinst_head, head_valid, count
   );
   modport slave (
      input  flush, enq_valid, enq_miinst, deq_en,
      output enq_ready, almost_full, deq_miinst_head, head_valid, count
   );
endinterface

// File: rtl/miinst_queue.sv
// miinst_queue: FIFO of decoded micro-instructions feeding decode_phase; head is NOP when empty.
// Optional same-cycle enq->head bypass when empty: define MIINST_QUEUE_BYPASS_EN.
module miinst_queue
   import miinst_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int AFULL_TH = 2
) (
   input logic            clk,
   input logic            rstn,
   miinst_queue_if.slave  q
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
   localparam logic [AW:0] TH_W    = AFULL_TH[AW:0];
   miinst_t     mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr, used;
   logic        empty, full, byp, do_enq, do_deq;
   miinst_t     head_src;
   assign used  = wr_ptr - rd_ptr;
   assign empty = wr_ptr == rd_ptr;
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) & (wr_ptr[AW] != rd_ptr[AW]);
`ifdef MIINST_QUEUE_BYPASS_EN
   assign byp      = empty & q.enq_valid & ~q.flush;
   assign head_src = byp ? q.enq_miinst : mem[rd_ptr[AW-1:0]];
`else
   assign byp      = 1'b0;
   assign head_src = mem[rd_ptr[AW-1:0]];
`endif
   // a bypassed entry consumed in the same cycle is never written
   assign do_enq = q.enq_valid & ~full & ~q.flush & ~(byp & q.deq_en);
   assign do_deq = q.deq_en & ~empty & ~q.flush;
   // status and head view derived from registered pointers (plus bypass path)
   always_comb begin
      q.enq_ready              = ~full;
      q.almost_full            = (DEPTH_W - used) <= TH_W;
      q.count                  = used;
      q.head_valid             = ~empty | byp;
      q.deq_miinst_head        = head_src;
      q.deq_miinst_head.opcode = q.head_valid ? head_src.opcode : MIOP_NOP;
   end
   // storage array, written only on an accepted enqueue
   always_ff @(posedge clk) begin
      if (do_enq) mem[wr_ptr[AW-1:0]] <= q.enq_miinst;
   end
   // pointer update; flush outranks any same-cycle enq/deq
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (q.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_enq) wr_ptr <= wr_ptr + 1'b1;
         if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      end
   end
endmodule

// File: tb/tb_miinst_queue.sv
// tb_miinst_queue: directed self-checking bench for miinst_queue
module tb_miinst_queue;
   import miinst_pkg::*;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   checks = 0;
   int   errors = 0;
   miinst_queue_if #(.DEPTH(16)) qi ();
   miinst_queue #(.DEPTH(16), .AFULL_TH(2)) dut (.clk(clk), .rstn(rstn), .q(qi));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic miinst_t mk(input logic [31:0] pc);
      miinst_t m;
      m = '0;
      m.opcode = MIOP_ALU;
      m.pc = pc;
      m.imm = ~pc;
      return m;
   endfunction
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic idle();
      qi.flush = 1'b0;
      qi.enq_valid = 1'b0;
      qi.deq_en = 1'b0;
   endtask
   task automatic push(input logic [31:0] pc);
      qi.enq_valid = 1'b1;
      qi.enq_miinst = mk(pc);
      tick();
      qi.enq_valid = 1'b0;
   endtask
   initial begin
      idle();
      qi.enq_miinst = '0;
      tick();
      tick();
      check("rst_count", 32'(qi.count), 0);
      check("rst_head_valid", 32'(qi.head_valid), 0);
      check("rst_opcode", 32'(qi.deq_miinst_head.opcode), 32'(MIOP_NOP));
      check("rst_enq_ready", 32'(qi.enq_ready), 1);
      check("rst_almost_full", 32'(qi.almost_full), 0);
      rstn = 1'b1;
      tick();
      // reset mid-traffic
      for (int i = 0; i < 5; i++) push(i);
      check("t1_count5", 32'(qi.count), 5);
      check("t1_head_pc", qi.deq_miinst_head.pc, 0);
      #2 rstn = 1'b0;
      #1;
      check("t1_rst_count", 32'(qi.count), 0);
      check("t1_rst_head_valid", 32'(qi.head_valid), 0);
      check("t1_rst_opcode", 32'(qi.deq_miinst_head.opcode), 32'(MIOP_NOP));
      check("t1_rst_enq_ready", 32'(qi.enq_ready), 1);
      @(negedge clk);
      rstn = 1'b1;
      tick();
      // fill to full, refuse 17th, drain in order
      for (int i = 0; i < 16; i++) begin
         push(i);
         if (i == 12) check("t2_af_13", 32'(qi.almost_full), 0);
         if (i == 13) check("t2_af_14", 32'(qi.almost_full), 1);
      end
      check("t2_count16", 32'(qi.count), 16);
      check("t2_enq_ready", 32'(qi.enq_ready), 0);
      check("t2_almost_full", 32'(qi.almost_full), 1);
      push(32'h99);
      check("t2_refused_count", 32'(qi.count), 16);
      qi.deq_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("t2_head_valid", 32'(qi.head_valid), 1);
         check("t2_head_pc", qi.deq_miinst_head.pc, 32'(i));
         tick();
      end
      check("t2_drained_valid", 32'(qi.head_valid), 0);
      check("t2_drained_opcode", 32'(qi.deq_miinst_head.opcode), 32'(MIOP_NOP));
      check("t2_drained_count", 32'(qi.count), 0);
      // dequeue while empty is ignored
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t5_empty_deq_count", 32'(qi.count), 0);
      end
      qi.deq_en = 1'b0;
      push(32'h77);
      check("t5_after_empty_count", 32'(qi.count), 1);
      check("t5_after_empty_pc", qi.deq_miinst_head.pc, 32'h77);
      qi.deq_en = 1'b1;
      tick();
      qi.deq_en = 1'b0;
      check("t5_drain_count", 32'(qi.count), 0);
      // steady enq/deq through pointer wrap
      for (int i = 0; i < 3; i++) push(100 + i);
      qi.deq_en = 1'b1;
      qi.enq_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         qi.enq_miinst = mk(103 + i);
         check("t3_head_pc", qi.deq_miinst_head.pc, 32'(100 + i));
         tick();
         check("t3_count", 32'(qi.count), 3);
      end
      idle();
      // flush with simultaneous enq and deq
      for (int i = 0; i < 4; i++) push(200 + i);
      check("t4_count7", 32'(qi.count), 7);
      qi.flush = 1'b1;
      qi.enq_valid = 1'b1;
      qi.deq_en = 1'b1;
      qi.enq_miinst = mk(32'h300);
      tick();
      idle();
      check("t4_count", 32'(qi.count), 0);
      check("t4_head_valid", 32'(qi.head_valid), 0);
      check("t4_opcode", 32'(qi.deq_miinst_head.opcode), 32'(MIOP_NOP));
      check("t4_enq_ready", 32'(qi.enq_ready), 1);
      tick();
      check("t4_not_stored", 32'(qi.count), 0);
      // full + enq + deq -> dequeue only
      for (int i = 0; i < 16; i++) push(32'h500 + i);
      check("t5_full", 32'(qi.count), 16);
      qi.enq_valid = 1'b1;
      qi.enq_miinst = mk(32'h5ff);
      qi.deq_en = 1'b1;
      tick();
      qi.enq_valid = 1'b0;
      check("t5_full_deq_count", 32'(qi.count), 15);
      for (int i = 0; i < 15; i++) begin
         check("t5_full_deq_pc", qi.deq_miinst_head.pc, 32'h501 + i);
         tick();
      end
      idle();
      check("t5_final_count", 32'(qi.count), 0);
      // enq into empty queue with deq_en in the same cycle
      qi.enq_valid = 1'b1;
      qi.enq_miinst = mk(32'h40);
      qi.deq_en = 1'b1;
      #1;
`ifdef MIINST_QUEUE_BYPASS_EN
      check("t6_byp_valid", 32'(qi.head_valid), 1);
      check("t6_byp_pc", qi.deq_miinst_head.pc, 32'h40);
      check("t6_byp_opcode", 32'(qi.deq_miinst_head.opcode), 32'(MIOP_ALU));
      tick();
      idle();
      check("t6_byp_count", 32'(qi.count), 0);
      check("t6_byp_after_valid", 32'(qi.head_valid), 0);
`else
      check("t6_nobyp_valid", 32'(qi.head_valid), 0);
      check("t6_nobyp_opcode", 32'(qi.deq_miinst_head.opcode), 32'(MIOP_NOP));
      tick();
      idle();
      check("t6_nobyp_count", 32'(qi.count), 1);
      check("t6_nobyp_pc", qi.deq_miinst_head.pc, 32'h40);
      check("t6_nobyp_valid_next", 32'(qi.head_valid), 1);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
